// File: rtl/cpu_sequencer.sv
// Instruction sequencer: owns the fetch pointer, a small return-address
// stack for CALL/RET, sticky stack-error flags and a RUN/HALT state.
module cpu_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    input  logic              resume,
    output logic [ADDR_W-1:0] instruction_pointer,
    output logic              halted,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_en;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] ip_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    assign ip_inc   = ip_q + ADDR_W'(1);
    assign push_idx = IDX_W'(lvl_q);
    assign pop_idx  = IDX_W'(lvl_q - LVL_W'(1));

    // Next-state and next-output decode for one sequencing step.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        ip_d    = ip_q;
        lvl_d   = lvl_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (enable) begin
                    case (op)
                        OP_JUMP:   ip_d = target;
                        OP_BRANCH: ip_d = cond ? target : ip_inc;
                        OP_CALL: begin
                            if (lvl_q < FULL_LVL) begin
                                push_en = 1'b1;
                                lvl_d   = lvl_q + LVL_W'(1);
                                ip_d    = target;
                            end else begin
                                ovf_d = 1'b1;
                                ip_d  = ip_inc;
                            end
                        end
                        OP_RET: begin
                            if (lvl_q != '0) begin
                                ip_d  = stack_mem[pop_idx];
                                lvl_d = lvl_q - LVL_W'(1);
                            end else begin
                                unf_d = 1'b1;
                                ip_d  = ip_inc;
                            end
                        end
                        // IP stays on the HALT instruction itself.
                        OP_HALT:   state_d = ST_HALT;
                        // OP_NEXT and the reserved encodings all advance.
                        default:   ip_d = ip_inc;
                    endcase
                end
            end
            ST_HALT: begin
                // enable and op are ignored while halted; only resume matters.
                if (resume) begin
                    state_d = ST_RUN;
                    ip_d    = ip_inc;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_RUN;
            ip_q    <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; written on a successful CALL.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; stack_level marks which entries are valid.
        if (push_en && !reset) begin
            stack_mem[push_idx] <= ip_inc;
        end
    end

    assign instruction_pointer = ip_q;
    assign halted              = (state_q == ST_HALT);
    assign stack_level         = lvl_q;
    assign stack_overflow      = ovf_q;
    assign stack_underflow     = unf_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios followed by
// randomized steps, all compared against a queue-based reference model.
module tb_cpu_sequencer;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int LVL_W       = $clog2(STACK_DEPTH + 1);

    localparam int NEXT = 0, JUMP = 1, BRANCH = 2, CALL = 3, RET = 4, HALT = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [2:0]        op = 3'd0;
    logic              cond = 1'b0;
    logic [ADDR_W-1:0] target = '0;
    logic              resume = 1'b0;
    logic [ADDR_W-1:0] instruction_pointer;
    logic              halted;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_overflow;
    logic              stack_underflow;

    cpu_sequencer #(
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .op                 (op),
        .cond               (cond),
        .target             (target),
        .resume             (resume),
        .instruction_pointer(instruction_pointer),
        .halted             (halted),
        .stack_level        (stack_level),
        .stack_overflow     (stack_overflow),
        .stack_underflow    (stack_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers plus a queue for the return stack.
    int m_ip;
    bit m_halted;
    bit m_ovf;
    bit m_unf;
    int m_stack[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic void model_edge(bit rst, bit en, int o, bit c, int tgt, bit res);
        int wrap_inc;
        wrap_inc = (m_ip + 1) % (1 << ADDR_W);
        if (rst) begin
            m_ip = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (m_halted) begin
            if (res) begin
                m_halted = 0;
                m_ip = wrap_inc;
            end
        end else if (en) begin
            if (o == JUMP) m_ip = tgt;
            else if (o == BRANCH) m_ip = c ? tgt : wrap_inc;
            else if (o == CALL) begin
                if (m_stack.size() < STACK_DEPTH) begin
                    m_stack.push_back(wrap_inc);
                    m_ip = tgt;
                end else begin
                    m_ovf = 1;
                    m_ip = wrap_inc;
                end
            end else if (o == RET) begin
                if (m_stack.size() > 0) m_ip = m_stack.pop_back();
                else begin
                    m_unf = 1;
                    m_ip = wrap_inc;
                end
            end else if (o == HALT) m_halted = 1;
            else m_ip = wrap_inc;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".ip"},    32'(instruction_pointer), 32'(m_ip));
        check({tag, ".halt"},  32'(halted),              32'(m_halted));
        check({tag, ".lvl"},   32'(stack_level),         32'(m_stack.size()));
        check({tag, ".ovf"},   32'(stack_overflow),      32'(m_ovf));
        check({tag, ".unf"},   32'(stack_underflow),     32'(m_unf));
    endtask

    // One clock edge: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic step(input string tag, input bit rst, input bit en, input int o,
                        input bit c, input int tgt, input bit res);
        reset  = rst;
        enable = en;
        op     = 3'(o);
        cond   = c;
        target = ADDR_W'(tgt);
        resume = res;
        @(posedge clk);
        model_edge(rst, en, o, c, tgt, res);
        #1;
        check_model(tag);
    endtask

    initial begin
        // Reset state
        step("rst", 1, 1, CALL, 0, 8'h33, 1);
        check("rst_ip", 32'(instruction_pointer), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);

        // NEXT steps with enable gaps
        step("nx1", 0, 1, NEXT, 0, 0, 0);
        step("gap1", 0, 0, JUMP, 0, 8'h99, 0);
        check("nx_gap1", 32'(instruction_pointer), 32'h1);
        step("nx2", 0, 1, NEXT, 0, 0, 0);
        step("gap2", 0, 0, CALL, 0, 8'h99, 1);
        step("nx3", 0, 1, NEXT, 0, 0, 0);
        check("nx_ip3", 32'(instruction_pointer), 32'h3);

        // Wrap at the top of the address space
        step("jff", 0, 1, JUMP, 0, 8'hFF, 0);
        check("jump_ff", 32'(instruction_pointer), 32'hFF);
        step("wrap", 0, 1, NEXT, 0, 0, 0);
        check("wrap_00", 32'(instruction_pointer), 32'h00);

        // Branch not-taken / taken
        step("j5a", 0, 1, JUMP, 0, 5, 0);
        step("br0", 0, 1, BRANCH, 0, 8'h20, 0);
        check("branch_nt", 32'(instruction_pointer), 32'h6);
        step("j5b", 0, 1, JUMP, 0, 5, 0);
        step("br1", 0, 1, BRANCH, 1, 8'h20, 0);
        check("branch_t", 32'(instruction_pointer), 32'h20);

        // Nested call / return
        step("j10", 0, 1, JUMP, 0, 8'h10, 0);
        step("c40", 0, 1, CALL, 0, 8'h40, 0);
        check("call1_lvl", 32'(stack_level), 32'd1);
        step("c80", 0, 1, CALL, 0, 8'h80, 0);
        check("call2_ip", 32'(instruction_pointer), 32'h80);
        step("r1", 0, 1, RET, 0, 0, 0);
        check("ret1_ip", 32'(instruction_pointer), 32'h41);
        step("r2", 0, 1, RET, 0, 0, 0);
        check("ret2_ip", 32'(instruction_pointer), 32'h11);
        check("ret2_lvl", 32'(stack_level), 32'd0);

        // Overflow on fifth CALL, underflow on RET at empty
        step("rst2", 1, 0, NEXT, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("cov", 0, 1, CALL, 0, 8'h30 + i, 0);
        check("ovf_flag", 32'(stack_overflow), 32'h1);
        check("ovf_lvl", 32'(stack_level), 32'd4);
        check("ovf_ip", 32'(instruction_pointer), 32'h34);
        for (int i = 0; i < 4; i++) step("rdr", 0, 1, RET, 0, 0, 0);
        check("drain_ip", 32'(instruction_pointer), 32'h1);
        step("run", 0, 1, RET, 0, 0, 0);
        check("unf_flag", 32'(stack_underflow), 32'h1);
        check("ovf_sticky", 32'(stack_overflow), 32'h1);

        // HALT, ignored enabled edges, resume, reset while halted
        step("j7", 0, 1, JUMP, 0, 7, 0);
        step("halt", 0, 1, HALT, 0, 0, 0);
        step("h1", 0, 1, JUMP, 0, 8'h55, 0);
        step("h2", 0, 1, CALL, 0, 8'h66, 0);
        step("h3", 0, 1, NEXT, 0, 0, 0);
        check("halt_ip", 32'(instruction_pointer), 32'h7);
        check("halt_flag", 32'(halted), 32'h1);
        step("res", 0, 1, JUMP, 0, 8'h55, 1);
        check("resume_ip", 32'(instruction_pointer), 32'h8);
        check("resume_halted", 32'(halted), 32'h0);
        step("res_run", 0, 0, NEXT, 0, 0, 1);
        check("resume_in_run", 32'(instruction_pointer), 32'h8);
        step("halt2", 0, 1, HALT, 0, 0, 0);
        step("rst_h", 1, 0, NEXT, 0, 0, 1);
        check("rst_halt_ip", 32'(instruction_pointer), 32'h0);
        check("rst_halt_flag", 32'(halted), 32'h0);

        // Randomized steps, including occasional resets mid-operation
        for (int i = 0; i < 3000; i++) begin
            int o;
            o = int'($urandom_range(0, 7));
            if (o == HALT && $urandom_range(0, 2) != 0) o = NEXT;
            step("rnd", $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, o,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction pointer and branch target width (4..16).
REQ-002 SHALL have parameter STACK_DEPTH, default 4: return-address stack entries (1..16).
REQ-003 SHALL have parameter LVL_W, default $clog2(STACK_DEPTH+1): stack_level width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  step strobe; at most one sequencing step per clk edge where enable=1.
REQ-007 op  input  3  sequencing op: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6/7 reserved.
REQ-008 cond  input  1  branch condition; used by BRANCH only.
REQ-009 target  input  ADDR_W  destination address for JUMP, BRANCH, CALL.
REQ-010 resume  input  1  releases HALT state.
REQ-011 instruction_pointer  output  ADDR_W  registered current fetch address.
REQ-012 halted  output  1  registered; 1 while in HALT state.
REQ-013 stack_level  output  LVL_W  registered count of occupied stack entries.
REQ-014 stack_overflow  output  1  registered sticky flag; CALL attempted with stack full.
REQ-015 stack_underflow  output  1  registered sticky flag; RET attempted with stack empty.

Function
REQ-016 SHALL implement two states, RUN and HALT; halted=1 exactly when state=HALT.
REQ-017 In RUN with enable=0 or at a HALT-state edge without resume, all registered outputs and stack contents SHALL hold.
REQ-018 RUN, enable=1, NEXT or reserved op: IP <= IP+1, modulo 2^ADDR_W (max value wraps to 0).
REQ-019 RUN, enable=1, JUMP: IP <= target.
REQ-020 RUN, enable=1, BRANCH: IP <= target when cond=1, else IP+1 (with wrap).
REQ-021 RUN, enable=1, CALL, stack_level<STACK_DEPTH: push IP+1 (wrapped), stack_level+1, IP <= target.
REQ-022 RUN, enable=1, CALL, stack_level=STACK_DEPTH: no push, stack_overflow <= 1, IP <= IP+1.
REQ-023 RUN, enable=1, RET, stack_level>0: IP <= top entry, stack_level-1.
REQ-024 RUN, enable=1, RET, stack_level=0: stack_underflow <= 1, IP <= IP+1.
REQ-025 RUN, enable=1, HALT: state <= HALT, IP holds (points at the HALT instruction).
REQ-026 HALT state, resume=1 at any edge (enable ignored): state <= RUN, IP <= IP+1 (with wrap); op that edge ignored.
REQ-027 resume=1 while in RUN SHALL have no effect.
REQ-028 Stack SHALL be LIFO; entry written by the Nth push is returned by the matching pop; entries above stack_level are don't-care.
REQ-029 Overflow/underflow flags SHALL stay set until reset; they do not block further operation.
REQ-030 Latency: every output change SHALL be visible one clk edge after the enabled step; no combinational path from inputs to outputs.

Reset
REQ-031 reset=1 at a clk edge SHALL force IP=0, state=RUN (halted=0), stack_level=0, stack_overflow=0, stack_underflow=0.
REQ-032 reset SHALL dominate enable, op and resume at the same edge, including mid-CALL, mid-RET and in HALT.
REQ-033 Stack entry contents need not be cleared by reset.

Verification
REQ-034 Reset then 3 NEXT steps with enable gaps between -> IP 0,1,2,3; IP holds on enable=0 cycles.
REQ-035 ADDR_W=8, JUMP target=0xFF then NEXT -> IP 0xFF then 0x00.
REQ-036 BRANCH target=0x20 with cond=0 at IP=5 -> IP=6; cond=1 -> IP=0x20.
REQ-037 At IP=0x10, CALL 0x40, CALL 0x80, RET, RET -> IP 0x40, 0x80, 0x41, 0x11; stack_level 1,2,1,0.
REQ-038 STACK_DEPTH=4: 5 CALLs -> stack_level=4, stack_overflow=1 after 5th, IP=prior IP+1; RET at level 0 -> stack_underflow=1.
REQ-039 HALT at IP=7, 3 enabled edges, then resume=1 -> IP stays 7, halted=1; after resume IP=8, halted=0; reset asserted in HALT -> IP=0, halted=0.
